// File: rtl/ace_controller.sv
// ACE master stage below the cache controller: ReadShared line fills, WriteBack
// evictions and CleanUnique invalidations, ending in a one-cycle ace_ready pulse.
module ace_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BEATS = 4,
  parameter int BEAT_W     = $clog2(LINE_BEATS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic                  invalid_req,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  ace_ready,
  output logic                  ace_err,
  output logic                  fill_valid,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic [BEAT_W-1:0]     fill_beat,
  output logic [BEAT_W-1:0]     wb_beat,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [3:0]            arsnoop,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [3:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsnoop,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  rack,
  output logic                  wack
);

  localparam int OFF_W = $clog2(LINE_BEATS * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [7:0]            LINE_LEN  = 8'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_RDATA = 3'd2,
    S_AW    = 3'd3,
    S_WDATA = 3'd4,
    S_BRESP = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_INV   = 2'd1,
    OP_WRITE = 2'd2
  } op_t;

  state_t                state_q;
  op_t                   op_q;
  logic [BEAT_W-1:0]     cnt_q;
  logic                  err_q;
  logic                  ace_ready_q, ace_err_q, rack_q, wack_q;
  logic [ADDR_WIDTH-1:0] araddr_q, awaddr_q;
  logic [7:0]            arlen_q, awlen_q;
  logic [3:0]            arsnoop_q;
  logic [2:0]            awsnoop_q;
  logic                  arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
  logic [BEAT_W-1:0]     wb_beat_q;

  logic                  cap_valid_d;
  op_t                   cap_op_d;
  logic [ADDR_WIDTH-1:0] cap_addr_d;
  logic [BEAT_W-1:0]     cnt_inc_d;

  // Only RRESP[1] / BRESP[1] carry meaning for the error flag.
  logic resp_unused_s;
  assign resp_unused_s = ^{rresp[3:2], rresp[0], bresp[0]};

  always_comb begin
    cap_valid_d = write_req | invalid_req | read_req;
    cap_addr_d  = req_addr & ~OFF_MASK;
    cnt_inc_d   = cnt_q + 1'b1;
    if (write_req) begin
      cap_op_d = OP_WRITE;
    end else if (invalid_req) begin
      cap_op_d = OP_INV;
    end else begin
      cap_op_d = OP_READ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      ace_ready_q <= 1'b0;
      ace_err_q   <= 1'b0;
      rack_q      <= 1'b0;
      wack_q      <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= 8'd0;
      arsnoop_q   <= 4'd0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      awlen_q     <= 8'd0;
      awsnoop_q   <= 3'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      wb_beat_q   <= '0;
    end else begin
      case (state_q)
        // DONE doubles as a capture cycle so back-to-back commands skip IDLE.
        S_IDLE, S_DONE: begin
          ace_ready_q <= 1'b0;
          ace_err_q   <= 1'b0;
          rack_q      <= 1'b0;
          wack_q      <= 1'b0;
          if (cap_valid_d) begin
            op_q      <= cap_op_d;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            wb_beat_q <= '0;
            if (cap_op_d == OP_WRITE) begin
              state_q   <= S_AW;
              awvalid_q <= 1'b1;
              awaddr_q  <= cap_addr_d;
              awlen_q   <= LINE_LEN;
              awsnoop_q <= 3'b011;
            end else begin
              state_q   <= S_AR;
              arvalid_q <= 1'b1;
              araddr_q  <= cap_addr_d;
              arlen_q   <= (cap_op_d == OP_INV) ? 8'd0 : LINE_LEN;
              arsnoop_q <= (cap_op_d == OP_INV) ? 4'b1011 : 4'b0001;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (rvalid) begin
            err_q <= err_q | rresp[1];
            if (rlast) begin
              rready_q    <= 1'b0;
              ace_ready_q <= 1'b1;
              rack_q      <= 1'b1;
              ace_err_q   <= err_q | rresp[1];
              state_q     <= S_DONE;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
        end
        S_AW: begin
          if (awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= 1'b0;
            state_q   <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (wready) begin
            if (cnt_q == LAST_BEAT) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= S_BRESP;
            end else begin
              cnt_q     <= cnt_inc_d;
              wb_beat_q <= cnt_inc_d;
              wlast_q   <= (cnt_inc_d == LAST_BEAT);
            end
          end
        end
        S_BRESP: begin
          if (bvalid) begin
            bready_q    <= 1'b0;
            ace_ready_q <= 1'b1;
            wack_q      <= 1'b1;
            ace_err_q   <= err_q | bresp[1];
            err_q       <= err_q | bresp[1];
            state_q     <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fill_valid = (state_q == S_RDATA) && rvalid && (op_q == OP_READ);
  assign fill_data  = fill_valid ? rdata : '0;
  assign fill_beat  = fill_valid ? cnt_q : '0;
  assign wdata      = wvalid_q ? wb_data : '0;

  assign ace_ready = ace_ready_q;
  assign ace_err   = ace_err_q;
  assign rack      = rack_q;
  assign wack      = wack_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsnoop   = arsnoop_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign awaddr    = awaddr_q;
  assign awlen     = awlen_q;
  assign awsnoop   = awsnoop_q;
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign wlast     = wlast_q;
  assign bready    = bready_q;
  assign wb_beat   = wb_beat_q;

endmodule

// File: tb/tb_ace_controller.sv
// Bench for ace_controller: cycle-level transaction model of the ACE handshakes
// driving directed and randomized traffic against simple slave responders.
module tb_ace_controller;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LB = 4;
  localparam int BW = 2;
  localparam int LINE_BYTES = LB * DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          read_req, write_req, invalid_req;
  logic [AW-1:0] req_addr;
  logic          ace_ready, ace_err, fill_valid;
  logic [DW-1:0] fill_data;
  logic [BW-1:0] fill_beat, wb_beat;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [3:0]    arsnoop;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [3:0]    rresp;
  logic          rlast, rvalid, rready;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsnoop;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic          wlast, wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic          rack, wack;
  logic [DW-1:0] wb_salt = 32'h1000_0000;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ace_controller dut (
    .clk(clk), .reset(reset),
    .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req), .req_addr(req_addr),
    .ace_ready(ace_ready), .ace_err(ace_err),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_beat(fill_beat),
    .wb_beat(wb_beat), .wb_data(wb_data),
    .araddr(araddr), .arlen(arlen), .arsnoop(arsnoop), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsnoop(awsnoop), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rack(rack), .wack(wack)
  );

  // Eviction data the cache datapath would present for a given beat index.
  function automatic logic [DW-1:0] wb_model(input logic [BW-1:0] k);
    return wb_salt ^ ({30'd0, k} * 32'h0101_0101);
  endfunction

  assign wb_data = wb_model(wb_beat);

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic outs_any();
    return |{ace_ready, ace_err, fill_valid, fill_data, fill_beat, wb_beat, araddr, arlen,
             arsnoop, arvalid, rready, awaddr, awlen, awsnoop, awvalid, wdata, wlast,
             wvalid, bready, rack, wack};
  endfunction

  task automatic slave_clear();
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 4'd0; rdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
  endtask

  // reqs = {write, invalid, read}; called at a negedge, returns one cycle later.
  task automatic issue(input logic [2:0] reqs, input logic [AW-1:0] addr);
    {write_req, invalid_req, read_req} = reqs;
    req_addr = addr;
    @(negedge clk);
    {write_req, invalid_req, read_req} = 3'b000;
    req_addr = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_value("idle_ready", {63'd0, ace_ready}, 64'd0);
      check_value("idle_valids", {62'd0, arvalid, awvalid}, 64'd0);
    end
  endtask

  function automatic int op_of(input logic [2:0] reqs);
    if (reqs[2]) return 2;
    if (reqs[1]) return 1;
    return 0;
  endfunction

  // op: 0 read, 1 invalidate, 2 write. mode: 0 zero-wait, 1 random, 2 alternate.
  // Returns at the negedge of the completion cycle (or after abort_beat is presented).
  task automatic service(input int op, input logic [AW-1:0] addr, input int mode,
                         input int ar_wait, input int err_beat, input logic [DW-1:0] rd_base,
                         input int abort_beat);
    int ph = 0;
    int nph;
    int k = 0;
    int cyc = 0;
    bit err = 1'b0;
    bit rdy;
    int nbeats;
    logic [AW-1:0] line;
    line = addr - (addr % LINE_BYTES);
    nbeats = (op == 0) ? LB : 1;
    forever begin
      slave_clear();
      nph = ph;
      if (cyc > 300) begin
        check_value("timeout", 64'd1, 64'd0);
        return;
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 2) rdy = (cyc % 2 == 1);
      else rdy = ($urandom_range(0, 2) != 0);

      check_value("ace_ready", {63'd0, ace_ready}, {63'd0, ph == 3});
      if (ph == 3) begin
        check_value("rack", {63'd0, rack}, {63'd0, op != 2});
        check_value("wack", {63'd0, wack}, {63'd0, op == 2});
        check_value("ace_err", {63'd0, ace_err}, {63'd0, err});
        return;
      end
      check_value("acks_idle", {62'd0, rack, wack}, 64'd0);
      check_value("arvalid", {63'd0, arvalid}, {63'd0, ph == 0 && op != 2});
      check_value("awvalid", {63'd0, awvalid}, {63'd0, ph == 0 && op == 2});
      check_value("rready", {63'd0, rready}, {63'd0, ph == 1 && op != 2});
      check_value("wvalid", {63'd0, wvalid}, {63'd0, ph == 1 && op == 2});
      check_value("bready", {63'd0, bready}, {63'd0, ph == 2});

      if (mode == 1 && $urandom_range(0, 3) == 0) begin
        {write_req, invalid_req, read_req} = 3'($urandom_range(1, 7));
        req_addr = $urandom;
      end else begin
        {write_req, invalid_req, read_req} = 3'b000;
      end

      if (ph == 0 && op != 2) begin
        check_value("araddr", 64'(araddr), 64'(line));
        check_value("arlen", 64'(arlen), (op == 0) ? 64'd3 : 64'd0);
        check_value("arsnoop", 64'(arsnoop), (op == 0) ? 64'h1 : 64'hB);
        arready = (cyc >= ar_wait) && rdy;
        if (arready) nph = 1;
      end
      if (ph == 0 && op == 2) begin
        check_value("awaddr", 64'(awaddr), 64'(line));
        check_value("awlen", 64'(awlen), 64'd3);
        check_value("awsnoop", 64'(awsnoop), 64'd3);
        awready = (cyc >= ar_wait) && rdy;
        if (awready) nph = 1;
      end
      if (ph == 1 && op != 2) begin
        rvalid = rdy;
        if (rvalid) begin
          rdata = (rd_base != 0) ? rd_base + DW'(k) : DW'($urandom);
          rlast = (k == nbeats - 1);
          rresp = (4'($urandom) & 4'b1101) | ((k == err_beat) ? 4'b0010 : 4'b0000);
          if (k == err_beat) err = 1'b1;
        end
      end
      if (ph == 1 && op == 2) begin
        check_value("wb_beat", 64'(wb_beat), 64'(k));
        check_value("wlast", {63'd0, wlast}, {63'd0, k == LB - 1});
        wready = rdy;
      end
      if (ph == 2) begin
        bvalid = rdy;
        bresp = {err_beat >= 0, 1'($urandom)};
        if (bvalid) begin
          if (err_beat >= 0) err = 1'b1;
          nph = 3;
        end
      end

      #1;
      check_value("fill_valid", {63'd0, fill_valid}, {63'd0, ph == 1 && op == 0 && rvalid});
      if (ph == 1 && op == 0 && rvalid) begin
        check_value("fill_data", 64'(fill_data), 64'(rdata));
        check_value("fill_beat", 64'(fill_beat), 64'(k));
      end
      if (ph == 1 && op == 2) begin
        check_value("wdata", 64'(wdata), 64'(wb_model(BW'(k))));
      end
      if (ph == 1 && op != 2 && rvalid) begin
        k++;
        if (rlast) nph = 3;
        if (op == 0 && abort_beat == k - 1) return;
      end
      if (ph == 1 && op == 2 && wready) begin
        k++;
        if (k == LB) nph = 2;
      end
      ph = nph;
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [2:0]    reqs;
    logic [AW-1:0] addr;
    int            mode;
    int            eb;
    reset = 1'b1;
    {write_req, invalid_req, read_req} = 3'b000;
    req_addr = '0;
    slave_clear();
    repeat (3) @(negedge clk);
    check_value("reset_outs", {63'd0, outs_any()}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_value("idle_outs", {63'd0, outs_any()}, 64'd0);

    // zero-wait ReadShared fill
    issue(3'b001, 32'h0000_1234);
    service(0, 32'h0000_1234, 0, 0, -1, 32'hA0, -1);
    idle(2);

    // writeback with wready on alternate cycles
    wb_salt = 32'h5A00_0000;
    issue(3'b100, 32'h8000_0047);
    service(2, 32'h8000_0047, 2, 0, -1, 0, -1);
    idle(1);

    // one-cycle invalidate with arready held low 3 cycles
    issue(3'b010, 32'h0000_5678);
    service(1, 32'h0000_5678, 0, 3, -1, 0, -1);
    idle(1);

    // writeback, then read captured in the DONE cycle
    issue(3'b100, 32'h0000_2000);
    service(2, 32'h0000_2000, 0, 0, -1, 0, -1);
    issue(3'b001, 32'h0000_3004);
    service(0, 32'h0000_3004, 0, 0, -1, 0, -1);
    idle(1);

    // error on beat 2, then a clean read clears the flag
    issue(3'b001, 32'h0000_0100);
    service(0, 32'h0000_0100, 0, 0, 2, 0, -1);
    idle(1);
    issue(3'b001, 32'h0000_0200);
    service(0, 32'h0000_0200, 0, 0, -1, 0, -1);
    idle(1);

    // reset in RDATA after beat 1, then a fresh read
    issue(3'b001, 32'h0000_0400);
    service(0, 32'h0000_0400, 0, 0, -1, 0, 1);
    @(negedge clk);
    slave_clear();
    reset = 1'b1;
    @(negedge clk);
    check_value("midreset_outs", {63'd0, outs_any()}, 64'd0);
    reset = 1'b0;
    issue(3'b001, 32'h0000_0500);
    service(0, 32'h0000_0500, 0, 0, -1, 0, -1);
    idle(1);

    // randomized traffic, including simultaneous commands and back-to-back capture
    for (int t = 0; t < 40; t++) begin
      reqs = 3'($urandom_range(1, 7));
      addr = $urandom;
      mode = $urandom_range(0, 2);
      eb = $urandom_range(0, 5) - 2;
      wb_salt = $urandom;
      issue(reqs, addr);
      service(op_of(reqs), addr, mode, $urandom_range(0, 2), eb, 0, -1);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
